// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter for the single-port sram macro with read-return tagging
// Ports: clk_i/rst_ni (async active-low reset); p0_*/p1_* requester req/we/addr/wdata/wmask in,
//   gnt/rvalid out; rdata_o shared read data; sram_* macro controls (csb/web active-low),
//   mask/addr/wdata out, rdata in.
// Macro SRAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to port 0.
module sram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [27:0]           p0_addr_i,
  input  logic [DATA_W-1:0]     p0_wdata_i,
  input  logic [DATA_W/8-1:0]   p0_wmask_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [27:0]           p1_addr_i,
  input  logic [DATA_W-1:0]     p1_wdata_i,
  input  logic [DATA_W/8-1:0]   p1_wmask_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [DATA_W/8-1:0]   sram_wmask_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_wdata_o,
  input  logic [DATA_W-1:0]     sram_rdata_i
);
  logic [RD_LAT-1:0] vld, prt;
  logic rd, unused_addr;
`ifdef SRAM_ARB_RR_EN
  logic ptr;
  assign p0_gnt_o = rst_ni & p0_req_i & (~p1_req_i | ~ptr);
  assign p1_gnt_o = rst_ni & p1_req_i & (~p0_req_i | ptr);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr <= 1'b0;
    else if (p0_gnt_o | p1_gnt_o) ptr <= p0_gnt_o;
`else
  assign p0_gnt_o = rst_ni & p0_req_i;
  assign p1_gnt_o = rst_ni & p1_req_i & ~p0_req_i;
`endif
  assign unused_addr = ^{p0_addr_i[27:ADDR_W], p1_addr_i[27:ADDR_W]};
  always_comb begin
    sram_csb_o   = ~(p0_gnt_o | p1_gnt_o);
    sram_web_o   = p0_gnt_o ? ~p0_we_i : p1_gnt_o ? ~p1_we_i : 1'b1;
    sram_wmask_o = p0_gnt_o ? p0_wmask_i : p1_gnt_o ? p1_wmask_i : '0;
    sram_addr_o  = p0_gnt_o ? p0_addr_i[ADDR_W-1:0] : p1_gnt_o ? p1_addr_i[ADDR_W-1:0] : '0;
    sram_wdata_o = p0_gnt_o ? p0_wdata_i : p1_gnt_o ? p1_wdata_i : '0;
    rd           = ~sram_csb_o & sram_web_o;
  end
  // stage 0 takes the tag of this cycle's granted read; the last stage lines up with sram_rdata_i
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      vld <= '0;
      prt <= '0;
    end else begin
      vld <= RD_LAT'({vld, rd});
      prt <= RD_LAT'({prt, p1_gnt_o});
    end
  assign p0_rvalid_o = vld[RD_LAT-1] & ~prt[RD_LAT-1];
  assign p1_rvalid_o = vld[RD_LAT-1] & prt[RD_LAT-1];
  assign rdata_o     = sram_rdata_i;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter with a behavioural sram model
module tb_sram_arbiter;
  logic clk_i = 0, rst_ni = 0;
  logic p0_req_i = 0, p0_we_i = 0, p1_req_i = 0, p1_we_i = 0;
  logic [27:0] p0_addr_i = 0, p1_addr_i = 0;
  logic [31:0] p0_wdata_i = 0, p1_wdata_i = 0, rdata_o, sram_wdata_o, sram_rdata_i;
  logic [3:0] p0_wmask_i = 0, p1_wmask_i = 0, sram_wmask_o;
  logic p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o, sram_csb_o, sram_web_o;
  logic [12:0] sram_addr_o;
  logic [31:0] mem [0:255];
  int checks = 0, errors = 0;
  sram_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_wmask_i(p0_wmask_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_wmask_i(p1_wmask_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
    .rdata_o(rdata_o), .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o),
    .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i)
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else sram_rdata_i <= mem[sram_addr_o[7:0]];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask
  task automatic ctl(input string tag, input logic g0, input logic g1, input logic csb, input logic web);
    #1;
    chk({tag, "_gnt"}, {p0_gnt_o, p1_gnt_o}, {g0, g1});
    chk({tag, "_csb_web"}, {sram_csb_o, sram_web_o}, {csb, web});
  endtask
  task automatic rv(input string tag, input logic v0, input logic v1, input logic [31:0] d);
    chk({tag, "_rvalid"}, {p0_rvalid_o, p1_rvalid_o}, {v0, v1});
    if (v0 | v1) chk({tag, "_rdata"}, rdata_o, d);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h20] = 32'hCAFEF00D;
    mem[8'h21] = 32'h55667788;
    sram_rdata_i = 0;
    p0_req_i = 1; p1_req_i = 1;
    ctl("reset", 0, 0, 1, 1);
    chk("reset_addr", {19'h0, sram_addr_o}, 0);
    chk("reset_mask", {28'h0, sram_wmask_o}, 0);
    cyc; cyc;
    rv("reset", 0, 0, 0);
    p0_req_i = 0; p1_req_i = 0;
    #1 rst_ni = 1;
    cyc;
    p0_req_i = 1; p0_we_i = 1; p0_addr_i = 28'h10; p0_wdata_i = 32'hDEADBEEF; p0_wmask_i = 4'hF;
    ctl("wr10", 1, 0, 0, 0);
    chk("wr10_addr", {19'h0, sram_addr_o}, 32'h10);
    cyc;
    rv("wr10_noread", 0, 0, 0);
    p0_we_i = 0; p0_addr_i = 28'hABC0010;
    ctl("rd10", 1, 0, 0, 1);
    chk("rd10_trunc", {19'h0, sram_addr_o}, 32'h10);
    cyc;
    p0_req_i = 0;
    rv("rd10", 1, 0, 32'hDEADBEEF);
    cyc;
    rv("rd10_idle", 0, 0, 0);
    p0_req_i = 1; p0_we_i = 1; p0_addr_i = 28'h30; p0_wdata_i = 32'h11223344; p0_wmask_i = 4'hF;
    cyc;
    p0_wdata_i = 32'hAABBCCDD; p0_wmask_i = 4'h3;
    cyc;
    p0_we_i = 0;
    ctl("rd30", 1, 0, 0, 1);
    cyc;
    p0_req_i = 0;
    rv("mask3", 1, 0, 32'h1122CCDD);
    p1_req_i = 1; p1_we_i = 0; p1_addr_i = 28'h20;
    ctl("p1rd20", 0, 1, 0, 1);
    cyc;
    p1_req_i = 0;
    p0_req_i = 1; p0_we_i = 1; p0_addr_i = 28'h21; p0_wdata_i = 32'hAABBCCDD; p0_wmask_i = 4'h5;
    #1;
    rv("p1rd20", 0, 1, 32'hCAFEF00D);
    ctl("p0wr21", 1, 0, 0, 0);
    cyc;
    rv("p0wr21_noread", 0, 0, 0);
    p0_we_i = 0;
    cyc;
    p0_req_i = 0;
    rv("rd21", 1, 0, 32'h55BB77DD);
    rst_ni = 0;
    cyc;
    rst_ni = 1;
    cyc;
    p0_req_i = 1; p0_we_i = 0; p0_addr_i = 28'h20;
    p1_req_i = 1; p1_we_i = 0; p1_addr_i = 28'h30;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      automatic logic w = i[0];
`else
      automatic logic w = 1'b0;
`endif
      ctl($sformatf("cont%0d", i), ~w, w, 0, 1);
      cyc;
      rv($sformatf("cont%0d", i), ~w, w, w ? 32'h1122CCDD : 32'hCAFEF00D);
    end
    p0_req_i = 0;
    ctl("p1after", 0, 1, 0, 1);
    cyc;
    p1_req_i = 0;
    rv("p1after", 0, 1, 32'h1122CCDD);
    p0_req_i = 1; p0_addr_i = 28'h10;
    ctl("rstrd", 1, 0, 0, 1);
    @(posedge clk_i);
    #1 p0_req_i = 0; rst_ni = 0;
    #1;
    rv("rst_drop", 0, 0, 0);
    ctl("rst_nognt", 0, 0, 1, 1);
    cyc;
    rv("rst_drop2", 0, 0, 0);
    rst_ni = 1;
    cyc;
    rv("rst_after", 0, 0, 0);
    p0_req_i = 1;
    ctl("rd_post", 1, 0, 0, 1);
    cyc;
    p0_req_i = 0;
    rv("rd_post", 1, 0, 32'hDEADBEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
